data_burst_packer: RTL and testbench

- Inverse of the xcorr burst-to-stream rate adapter. Accepts sparse single IQ samples (in_valid at arbitrary duty cycle) and packs them into ping-pong banks of BURST_LEN.
- Emits each full bank as one contiguous burst: out_valid high for exactly BURST_LEN consecutive cycles, with SOP/EOP markers.
- Sits between the decimating Rx front end and burst-oriented consumers (xcorr engine, Ethernet framer). Single clock domain.

---
 rtl/data_burst_packer.sv | 243 ++++++++++++++++++++++++
 tb/tb_data_burst_packer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_burst_packer.sv
// data_burst_packer: packs sparse IQ samples into two ping-pong banks of
// BURST_LEN entries and replays each full bank as one contiguous burst
// framed by SOP/EOP. Samples arriving while both banks are full are dropped
// and counted.
module data_burst_packer #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST_LEN  = 2048,
    parameter int MIN_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [DATA_WIDTH-1:0] in_data_q,
    input  logic                  in_valid,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data_i,
    output logic [DATA_WIDTH-1:0] out_data_q,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int IW = $clog2(BURST_LEN);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDX_PENULT = IW'(BURST_LEN - 2);
    localparam logic [GW-1:0] GAP_LAST   = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : GW'(0);

    typedef enum logic {
        WR_FILL,
        WR_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_GAP
    } rd_state_t;

    // Bank storage: entry address is {bank, index}, data is {I, Q}.
    logic [2*DATA_WIDTH-1:0] r_mem [2*BURST_LEN];
    logic [2*DATA_WIDTH-1:0] r_rd_q;

    // Writer state
    wr_state_t   r_wr_state, w_wr_state_nxt;
    logic        r_wr_bank,  w_wr_bank_nxt;
    logic [IW-1:0] r_wr_idx, w_wr_idx_nxt;
    logic [IW-1:0] w_wr_addr_idx;
    logic        w_wr_en;
    logic        w_set_full;
    logic        w_drop;
    logic        w_other_free;

    // Shared bank status
    logic [1:0]  r_bank_full;
    logic [1:0]  w_set_mask;
    logic [1:0]  w_clr_mask;

    // Reader state
    rd_state_t   r_rd_state, w_rd_state_nxt;
    logic        r_rd_bank;
    logic        r_rd_mem_bank;
    logic [IW-1:0] r_rd_idx;
    logic        r_rd_en;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic        w_rd_start;
    logic        w_rd_clear;

    // Output pipeline and error status
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;
    logic        r_overflow;
    logic [15:0] r_drop_count;

    // The other bank is usable if it is empty now or the reader releases it this edge.
    assign w_other_free = !r_bank_full[~r_wr_bank] || (w_rd_clear && (r_rd_bank == ~r_wr_bank));

    assign w_set_mask = w_set_full ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr_mask = w_rd_clear ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // Writer next-state: place samples, detect bank completion, drop when both banks are busy.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        w_wr_state_nxt = r_wr_state;
        w_wr_bank_nxt  = r_wr_bank;
        w_wr_idx_nxt   = r_wr_idx;
        w_wr_addr_idx  = r_wr_idx;
        w_wr_en        = 1'b0;
        w_set_full     = 1'b0;
        w_drop         = 1'b0;
        case (r_wr_state)
            WR_FILL: begin
                // flush abandons the partial bank; a sample in the same cycle restarts it at 0
                if (flush) begin
                    w_wr_addr_idx = '0;
                    w_wr_idx_nxt  = '0;
                end
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (w_wr_addr_idx == IDX_LAST) begin
                        w_set_full   = 1'b1;
                        w_wr_idx_nxt = '0;
                        if (w_other_free) begin
                            w_wr_bank_nxt = ~r_wr_bank;
                        end else begin
                            w_wr_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_wr_idx_nxt = w_wr_addr_idx + 1'b1;
                    end
                end
            end
            WR_DROP: begin
                // the sample in the cycle the other bank frees is still discarded;
                // filling resumes at index 0 on the following cycle
                w_drop = in_valid;
                if (w_other_free) begin
                    w_wr_bank_nxt  = ~r_wr_bank;
                    w_wr_state_nxt = WR_FILL;
                end
            end
            default: w_wr_state_nxt = WR_FILL;
        endcase
    end

    // Reader next-state: start on a full bank, step addresses, release the bank, then idle for MIN_GAP.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_rd_start     = 1'b0;
        w_rd_clear     = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_rd_start     = 1'b1;
                    w_rd_state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                // this edge issues the final address, so the bank can be handed back
                if (r_rd_idx == IDX_PENULT) begin
                    w_rd_clear     = 1'b1;
                    w_gap_cnt_nxt  = '0;
                    w_rd_state_nxt = (MIN_GAP == 0) ? RD_IDLE : RD_GAP;
                end
            end
            RD_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_rd_state_nxt = RD_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Writer state register, bank flags and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_wr_state   <= WR_FILL;
            r_wr_bank    <= 1'b0;
            r_wr_idx     <= '0;
            r_bank_full  <= 2'b00;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_state  <= w_wr_state_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    // Reader state register and read-address issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state    <= RD_IDLE;
            r_rd_bank     <= 1'b0;
            r_rd_mem_bank <= 1'b0;
            r_rd_idx      <= '0;
            r_rd_en       <= 1'b0;
            r_gap_cnt     <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            if (w_rd_start) begin
                r_rd_en       <= 1'b1;
                r_rd_idx      <= '0;
                r_rd_mem_bank <= r_rd_bank;
            end else if (r_rd_state == RD_BURST) begin
                // r_rd_mem_bank holds while r_rd_bank already points at the next bank
                r_rd_idx <= r_rd_idx + 1'b1;
                if (w_rd_clear) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else begin
                r_rd_en <= 1'b0;
            end
        end
    end

    // Bank RAM: synchronous write, registered read one cycle after the address.
    always_ff @(posedge clk) begin
        // NOTE: the RAM is not reset; bank_full gating guarantees stale contents are never emitted.
        if (w_wr_en) begin
            r_mem[{r_wr_bank, w_wr_addr_idx}] <= {in_data_i, in_data_q};
        end
        r_rd_q <= r_mem[{r_rd_mem_bank, r_rd_idx}];
    end

    // Output framing aligned with the registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            r_out_valid <= r_rd_en;
            r_out_sop   <= r_rd_en && (r_rd_idx == '0);
            r_out_eop   <= r_rd_en && (r_rd_idx == IDX_LAST);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign out_data_i = r_out_valid ? r_rd_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out_data_q = r_out_valid ? r_rd_q[DATA_WIDTH-1:0] : '0;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_data_burst_packer.sv
// tb_data_burst_packer: directed scenarios for the ping-pong burst packer
// with BURST_LEN=8, MIN_GAP=2, DATA_WIDTH=12.
module tb_data_burst_packer;

    localparam int DW = 12;
    localparam int BL = 8;
    localparam int MG = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic [DW-1:0] in_data_q = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] out_data_i;
    logic [DW-1:0] out_data_q;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          overflow;
    logic [15:0]   drop_count;

    typedef struct {
        logic [DW-1:0] di;
        logic [DW-1:0] dq;
        logic          sop;
        logic          eop;
        int            cyc;
    } beat_t;

    beat_t beats[$];
    int    cyc = 0;
    int    last_edge = 0;
    int    bad_idle = 0;
    int    checks = 0;
    int    failures = 0;

    data_burst_packer #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .MIN_GAP   (MG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data_i (in_data_i),
        .in_data_q (in_data_q),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data_i(out_data_i),
        .out_data_q(out_data_q),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                beat_t b;
                b.di  = out_data_i;
                b.dq  = out_data_q;
                b.sop = out_sop;
                b.eop = out_eop;
                b.cyc = cyc;
                beats.push_back(b);
            end else if (out_data_i != '0 || out_data_q != '0 || out_sop || out_eop) begin
                bad_idle++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sample accepted at the next edge, then 'gap' empty cycles.
    task automatic send(input int i, input int q, input int gap);
        in_valid  = 1'b1;
        in_data_i = DW'(i);
        in_data_q = DW'(q);
        @(posedge clk);
        #1;
        last_edge = cyc;
        in_valid  = 1'b0;
        idle(gap);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        idle(3);
        rst_n = 1'b1;
        beats.delete();
        idle(1);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got v/s/e=%b%b%b want 000", out_valid, out_sop, out_eop);
        end
        checks++;
        if (out_data_i !== '0 || out_data_q !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h want 0/0", out_data_i, out_data_q);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_status: got ovf=%b drops=%0d want 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_single_burst();
        int errs;
        apply_reset();
        for (int k = 1; k <= 8; k++) send(k, -k, 2);
        idle(20);
        checks++;
        if (beats.size() !== 8) begin
            failures++;
            $display("FAIL single_count: got %0d beats want 8", beats.size());
        end else begin
            checks++;
            if (beats[0].cyc !== last_edge + 2) begin
                failures++;
                $display("FAIL single_latency: got first beat at edge %0d want %0d", beats[0].cyc, last_edge + 2);
            end
            errs = 0;
            for (int k = 0; k < 8; k++) begin
                if (beats[k].di !== DW'(k + 1) || beats[k].dq !== DW'(-(k + 1)) ||
                    beats[k].cyc !== beats[0].cyc + k ||
                    beats[k].sop !== (k == 0) || beats[k].eop !== (k == 7)) errs++;
            end
            checks++;
            if (errs !== 0) begin
                failures++;
                $display("FAIL single_beats: got %0d bad beats want 0", errs);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_three_bursts();
        int errs;
        apply_reset();
        for (int k = 1; k <= 24; k++) send(k, 2 * k, 3);
        idle(20);
        checks++;
        if (beats.size() !== 24) begin
            failures++;
            $display("FAIL three_count: got %0d beats want 24", beats.size());
        end else begin
            errs = 0;
            for (int k = 0; k < 24; k++) begin
                if (beats[k].di !== DW'(k + 1) || beats[k].dq !== DW'(2 * (k + 1)) ||
                    beats[k].sop !== (k % 8 == 0) || beats[k].eop !== (k % 8 == 7)) errs++;
                if (k % 8 != 0 && beats[k].cyc !== beats[k-1].cyc + 1) errs++;
                if (k % 8 == 0 && k > 0 && (beats[k].cyc - beats[k-1].cyc - 1) < MG) errs++;
            end
            checks++;
            if (errs !== 0) begin
                failures++;
                $display("FAIL three_order: got %0d bad beats want 0", errs);
            end
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL three_drops: got ovf=%b drops=%0d want 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_overflow();
        int errs;
        int seen;
        int prev;
        apply_reset();
        for (int k = 1; k <= 40; k++) send(k, k, 0);
        // slow filler values push out whatever bank was left partial
        for (int k = 0; k < 8; k++) send(500 + k, 0, 3);
        idle(30);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        checks++;
        if (beats.size() % 8 !== 0 || beats.size() < 16) begin
            failures++;
            $display("FAIL ovf_beatcount: got %0d beats want nonzero multiple of 8", beats.size());
        end
        errs = 0;
        seen = 0;
        prev = 0;
        for (int k = 0; k < beats.size(); k++) begin
            if (beats[k].sop !== (k % 8 == 0) || beats[k].eop !== (k % 8 == 7)) errs++;
            if (k % 8 != 0 && beats[k].cyc !== beats[k-1].cyc + 1) errs++;
            if (int'(beats[k].di) <= 40) begin
                if (int'(beats[k].di) <= prev) errs++;
                if (k % 8 != 0 && int'(beats[k-1].di) <= 40 && int'(beats[k].di) !== int'(beats[k-1].di) + 1) errs++;
                prev = int'(beats[k].di);
                seen++;
            end
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL ovf_bursts: got %0d framing/order errors want 0", errs);
        end
        checks++;
        if (int'(drop_count) !== 40 - seen || drop_count === 16'd0) begin
            failures++;
            $display("FAIL ovf_dropcount: got %0d want %0d (nonzero)", drop_count, 40 - seen);
        end
    endtask

    task automatic test_flush();
        int errs;
        apply_reset();
        for (int k = 1; k <= 5; k++) send(k, k, 2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        for (int k = 100; k <= 107; k++) send(k, k, 2);
        idle(20);
        checks++;
        if (beats.size() !== 8) begin
            failures++;
            $display("FAIL flush_count: got %0d beats want 8", beats.size());
        end else begin
            errs = 0;
            for (int k = 0; k < 8; k++)
                if (beats[k].di !== DW'(100 + k) || beats[k].sop !== (k == 0) || beats[k].eop !== (k == 7)) errs++;
            checks++;
            if (errs !== 0) begin
                failures++;
                $display("FAIL flush_data: got %0d bad beats want 0", errs);
            end
        end
        // flush together with a sample: that sample becomes index 0
        beats.delete();
        for (int k = 1; k <= 3; k++) send(k, k, 2);
        flush = 1'b1;
        send(200, 200, 0);
        flush = 1'b0;
        for (int k = 201; k <= 207; k++) send(k, k, 2);
        idle(20);
        checks++;
        if (beats.size() !== 8) begin
            failures++;
            $display("FAIL flush_valid_count: got %0d beats want 8", beats.size());
        end else begin
            errs = 0;
            for (int k = 0; k < 8; k++)
                if (beats[k].di !== DW'(200 + k)) errs++;
            checks++;
            if (errs !== 0 || beats[0].sop !== 1'b1) begin
                failures++;
                $display("FAIL flush_valid_data: got first=%0d errs=%0d want first=200 errs=0", beats[0].di, errs);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found;
        int errs;
        apply_reset();
        for (int k = 1; k <= 8; k++) send(k, k, 1);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            #1;
            if (beats.size() >= 4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midrst_wait: got %0d beats want 4 within 100 cycles", beats.size());
        end else begin
            checks++;
            if (beats[3].di !== DW'(4) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL midrst_beat4: got di=%0d v=%b want 4/1", beats[3].di, out_valid);
            end
            #1;
            rst_n = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data_i !== '0) begin
                failures++;
                $display("FAIL midrst_async: got v/s/e=%b%b%b di=%0d want 000/0", out_valid, out_sop, out_eop, out_data_i);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beats.delete();
        idle(30);
        checks++;
        if (beats.size() !== 0) begin
            failures++;
            $display("FAIL midrst_silent: got %0d beats want 0", beats.size());
        end
        for (int k = 50; k <= 57; k++) send(k, k, 1);
        idle(20);
        errs = 0;
        if (beats.size() == 8) begin
            for (int k = 0; k < 8; k++)
                if (beats[k].di !== DW'(50 + k) || beats[k].sop !== (k == 0) || beats[k].eop !== (k == 7)) errs++;
        end
        checks++;
        if (beats.size() !== 8 || errs !== 0) begin
            failures++;
            $display("FAIL midrst_recover: got %0d beats errs=%0d want 8/0", beats.size(), errs);
        end
    endtask

    task automatic test_same_edge_free();
        int errs;
        apply_reset();
        // bank 1 completes on the edge that issues bank 0's last read address
        for (int k = 1; k <= 17; k++) send(k, k, 0);
        for (int k = 18; k <= 24; k++) send(k, k, 3);
        idle(20);
        checks++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_drops: got drops=%0d ovf=%b want 0/0", drop_count, overflow);
        end
        errs = 0;
        if (beats.size() == 24) begin
            for (int k = 0; k < 24; k++) begin
                if (beats[k].di !== DW'(k + 1) || beats[k].sop !== (k % 8 == 0) || beats[k].eop !== (k % 8 == 7)) errs++;
                if (k % 8 != 0 && beats[k].cyc !== beats[k-1].cyc + 1) errs++;
            end
        end
        checks++;
        if (beats.size() !== 24 || errs !== 0) begin
            failures++;
            $display("FAIL same_edge_bursts: got %0d beats errs=%0d want 24/0", beats.size(), errs);
        end
    endtask

    task automatic test_idle_zero();
        checks++;
        if (bad_idle !== 0) begin
            failures++;
            $display("FAIL idle_zero: got %0d nonzero idle cycles want 0", bad_idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_three_bursts();
        test_overflow();
        test_flush();
        test_reset_mid_burst();
        test_same_edge_free();
        test_idle_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
